acc_step_ctrl: RTL

ACC_STEP_CTRL -- requirements
Module: acc_step_ctrl

---
 rtl/acc_ctrl_pkg.sv | 17 +
 rtl/acc_alu.sv | 38 +++
 rtl/acc_step_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/acc_ctrl_pkg.sv
// Shared types and constants for the step/run accumulator controller.
package acc_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 7;
  localparam int unsigned DEF_CNT_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU: add or reverse-subtract with carry/borrow.
// Define ACC_SATURATE_EN to clamp on overflow/borrow instead of wrapping.
module acc_alu
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] operand,
  input  logic             op_sub,
  output logic [WIDTH-1:0] next_result,
  output logic             next_carry
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    sum         = {1'b0, result} + {1'b0, operand};
    diff        = operand - result;
    borrow      = (operand < result);
    next_result = sum[WIDTH-1:0];
    next_carry  = sum[WIDTH];
    if (op_sub == OP_SUB) begin
      next_result = diff;
      next_carry  = borrow;
`ifdef ACC_SATURATE_EN
      if (borrow) next_result = '0;
`endif
    end else begin
`ifdef ACC_SATURATE_EN
      if (sum[WIDTH]) next_result = '1;
`endif
    end
  end

endmodule

// File: rtl/acc_step_ctrl.sv
// Step/run accumulator controller: edge-triggered FSM driving acc_alu.
// Saturating arithmetic is selected with the ACC_SATURATE_EN macro.
module acc_step_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             step_in,
  input  logic             clear_n,
  input  logic             mode_run,
  input  logic [CNT_W-1:0] run_count,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q;
  logic             armed_q;
  logic             trigger;
  logic             op_en;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  // armed_q masks the first cycle after reset so a held-high button cannot trigger
  assign trigger = armed_q & step_in & ~step_q;

  acc_alu #(.WIDTH(WIDTH)) u_alu (
    .result      (result),
    .operand     (operand),
    .op_sub      (op_sub),
    .next_result (alu_result),
    .next_carry  (alu_carry)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          if (!mode_run) begin
            state_d = STEP;
          end else if (run_count != '0) begin
            state_d = RUN;
            cnt_d   = run_count;
          end else begin
            state_d = DONE;
          end
        end
      end
      STEP: begin
        op_en   = 1'b1;
        state_d = DONE;
      end
      RUN: begin
        op_en = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // clear aborts everything, including a simultaneous trigger
    if (!clear_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      op_en   = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      armed_q <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_in;
      armed_q <= 1'b1;
      busy    <= (state_d == STEP) || (state_d == RUN);
      done    <= (state_d == DONE);
      if (!clear_n) begin
        result <= '0;
        carry  <= 1'b0;
      end else if (op_en) begin
        result <= alu_result;
        carry  <= alu_carry;
      end
    end
  end

endmodule
